// File: rtl/rect_buffer_coord_stream.sv
`default_nettype none
// ============================================================================
//  Module      : rect_buffer_coord_stream
//  Description : Write-side coordinate generator for the rect buffer. Accepts
//                one block-row command (start, signed delta, run mode, gray)
//                and streams one interpolated coordinate per cycle with
//                valid/ready backpressure and zero-bubble command chaining.
//                Optional macro COORD_ROUND_EN selects round-half-up output
//                instead of floor.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_buffer_coord_stream #(
  parameter int BLK_W     = 32,
  parameter int COORD_W   = 16,
  parameter int DELTA_W   = 16,
  parameter int MAX_SHIFT = 2
) (
  input  logic                       st_clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COORD_W-1:0]         in_start_x,
  input  logic [COORD_W-1:0]         in_start_y,
  input  logic [DELTA_W-1:0]         in_dx,
  input  logic [DELTA_W-1:0]         in_dy,
  input  logic [1:0]                 in_mode,
  input  logic                       in_gray,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COORD_W-1:0]         out_x,
  output logic [COORD_W-1:0]         out_y,
  output logic [$clog2(BLK_W)-1:0]   out_col,
  output logic                       out_last,
  output logic                       out_gray
);

  // Column index width and accumulator width (sign bit + integer + fraction).
  localparam int c_col_w = $clog2(BLK_W);
  localparam int c_acc_w = COORD_W + c_col_w + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic signed [c_acc_w-1:0]  r_acc_x;
  logic signed [c_acc_w-1:0]  r_acc_y;
  logic signed [c_acc_w-1:0]  r_step_x;
  logic signed [c_acc_w-1:0]  r_step_y;
  logic [c_col_w-1:0]         r_col;
  logic [c_col_w-1:0]         r_last_col;
  logic                       r_gray;

  logic [1:0]                 w_mode_clamped;
  logic [c_col_w-1:0]         w_last_col;
  logic signed [c_acc_w-1:0]  w_step_x;
  logic signed [c_acc_w-1:0]  w_step_y;
  logic signed [c_acc_w-1:0]  w_start_x;
  logic signed [c_acc_w-1:0]  w_start_y;
  logic signed [c_acc_w-1:0]  w_out_acc_x;
  logic signed [c_acc_w-1:0]  w_out_acc_y;
  logic                       w_fire;
  logic                       w_fire_last;
  logic                       w_accept;

  // Command decode: clamp the run shift, derive run length and the per-column
  // step. The step is the delta scaled up by the shift so shorter runs cover
  // the same span as a full run.
  assign w_mode_clamped = (in_mode > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : in_mode;
  assign w_last_col     = c_col_w'((BLK_W >> w_mode_clamped) - 1);
  assign w_step_x       = {{(c_acc_w-DELTA_W){in_dx[DELTA_W-1]}}, in_dx} << w_mode_clamped;
  assign w_step_y       = {{(c_acc_w-DELTA_W){in_dy[DELTA_W-1]}}, in_dy} << w_mode_clamped;
  assign w_start_x      = {1'b0, in_start_x, {c_col_w{1'b0}}};
  assign w_start_y      = {1'b0, in_start_y, {c_col_w{1'b0}}};

  // Handshakes. A new command may be taken while the last beat of the current
  // run is being consumed, which removes the bubble between runs.
  assign out_valid   = (r_state == RUN);
  assign out_last    = out_valid && (r_col == r_last_col);
  assign w_fire      = out_valid && out_ready;
  assign w_fire_last = w_fire && out_last;
  assign in_ready    = (r_state == IDLE) || w_fire_last;
  assign w_accept    = in_valid && in_ready;

  // State register.
  always_ff @(posedge st_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: enter RUN on acceptance, leave only when the last beat
  // drains with no follow-on command.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_fire_last && !in_valid) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, advance on every non-last accepted beat,
  // hold otherwise so a stalled beat is presented unchanged.
  always_ff @(posedge st_clk) begin
    if (reset) begin
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_step_x   <= '0;
      r_step_y   <= '0;
      r_col      <= '0;
      r_last_col <= '0;
      r_gray     <= 1'b0;
    end else if (w_accept) begin
      r_acc_x    <= w_start_x;
      r_acc_y    <= w_start_y;
      r_step_x   <= w_step_x;
      r_step_y   <= w_step_y;
      r_col      <= '0;
      r_last_col <= w_last_col;
      r_gray     <= in_gray;
    end else if (w_fire && !out_last) begin
      r_acc_x    <= r_acc_x + r_step_x;
      r_acc_y    <= r_acc_y + r_step_y;
      r_col      <= r_col + 1'b1;
    end
  end

  // Output conversion. Rounding only biases the output path; the accumulators
  // keep their exact fractional value.
`ifdef COORD_ROUND_EN
  localparam logic signed [c_acc_w-1:0] c_half = c_acc_w'(BLK_W / 2);
  assign w_out_acc_x = r_acc_x + c_half;
  assign w_out_acc_y = r_acc_y + c_half;
`else
  assign w_out_acc_x = r_acc_x;
  assign w_out_acc_y = r_acc_y;
`endif

  // Arithmetic shift then truncate: floor division with modulo wrap.
  assign out_x    = COORD_W'(w_out_acc_x >>> c_col_w);
  assign out_y    = COORD_W'(w_out_acc_y >>> c_col_w);
  assign out_col  = r_col;
  assign out_gray = r_gray;

endmodule
`default_nettype wire

// File: tb/tb_rect_buffer_coord_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_buffer_coord_stream
//  Description : Directed self-checking bench for rect_buffer_coord_stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_buffer_coord_stream;

  logic        st_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_start_x;
  logic [15:0] in_start_y;
  logic [15:0] in_dx;
  logic [15:0] in_dy;
  logic [1:0]  in_mode;
  logic        in_gray;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [4:0]  out_col;
  logic        out_last;
  logic        out_gray;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ex [32];
  logic [15:0] ey [32];

  rect_buffer_coord_stream #(
    .BLK_W     (32),
    .COORD_W   (16),
    .DELTA_W   (16),
    .MAX_SHIFT (2)
  ) dut (
    .st_clk     (st_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_start_x (in_start_x),
    .in_start_y (in_start_y),
    .in_dx      (in_dx),
    .in_dy      (in_dy),
    .in_mode    (in_mode),
    .in_gray    (in_gray),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_col    (out_col),
    .out_last   (out_last),
    .out_gray   (out_gray)
  );

  // Clock generation.
  always #5 st_clk = ~st_clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

  task automatic tick();
    @(posedge st_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [15:0] sx, input logic [15:0] sy,
                      input logic [15:0] dx, input logic [15:0] dy,
                      input logic [1:0] mode, input logic gray);
    in_start_x = sx;
    in_start_y = sy;
    in_dx      = dx;
    in_dy      = dy;
    in_mode    = mode;
    in_gray    = gray;
    in_valid   = 1'b1;
    #1;
    chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Walks n beats against ex/ey. Optional stall at one column, optional reset
  // pulse at one column, and a chained command expected right after the run.
  task automatic beats(input string tag, input int n, input logic g, input logic chain,
                       input int stall_at, input int abort_at);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s valid c%0d", tag, c), 32'(out_valid), 32'd1);
      chk($sformatf("%s col c%0d", tag, c), 32'(out_col), 32'(c));
      chk($sformatf("%s x c%0d", tag, c), 32'(out_x), 32'(ex[c]));
      chk($sformatf("%s y c%0d", tag, c), 32'(out_y), 32'(ey[c]));
      chk($sformatf("%s last c%0d", tag, c), 32'(out_last), 32'(c == n - 1));
      chk($sformatf("%s gray c%0d", tag, c), 32'(out_gray), 32'(g));
      chk($sformatf("%s in_ready c%0d", tag, c), 32'(in_ready), 32'(c == n - 1));
      if (c == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk($sformatf("%s stall%0d valid", tag, k), 32'(out_valid), 32'd1);
          chk($sformatf("%s stall%0d col", tag, k), 32'(out_col), 32'(c));
          chk($sformatf("%s stall%0d x", tag, k), 32'(out_x), 32'(ex[c]));
          chk($sformatf("%s stall%0d last", tag, k), 32'(out_last), 32'd0);
          chk($sformatf("%s stall%0d in_ready", tag, k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      if (c == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk({tag, " abort valid"}, 32'(out_valid), 32'd0);
        chk({tag, " abort last"}, 32'(out_last), 32'd0);
        chk({tag, " abort col"}, 32'(out_col), 32'd0);
        chk({tag, " abort in_ready"}, 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
          tick();
          chk($sformatf("%s after abort %0d valid", tag, k), 32'(out_valid), 32'd0);
        end
        return;
      end
      tick();
    end
    chk({tag, " end valid"}, 32'(out_valid), 32'(chain));
    if (chain) begin
      chk({tag, " chained col"}, 32'(out_col), 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_start_x = '0;
    in_start_y = '0;
    in_dx      = '0;
    in_dy      = '0;
    in_mode    = '0;
    in_gray    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;

    // Reset state.
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_col", 32'(out_col), 32'd0);
    chk("rst out_x", 32'(out_x), 32'd0);
    chk("rst out_y", 32'(out_y), 32'd0);
    chk("rst out_gray", 32'(out_gray), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    tick();

    // A: full run, +1 per column in x.
    for (int c = 0; c < 32; c++) begin ex[c] = 16'(100 + c); ey[c] = 16'd50; end
    send("A", 16'd100, 16'd50, 16'd32, 16'd0, 2'd0, 1'b1);
    beats("A", 32, 1'b1, 1'b0, -1, -1);

    // B: half run, x -1 per column, y -2 per column wrapping below zero.
    for (int c = 0; c < 16; c++) begin ex[c] = 16'(100 - c); ey[c] = 16'(3 - 2 * c); end
    send("B", 16'd100, 16'd3, 16'hFFF0, 16'hFFE0, 2'd1, 1'b0);
    beats("B", 16, 1'b0, 1'b0, -1, -1);

    // C: mode 3 clamps to quarter run, +4 per column, y wraps past 0xFFFF.
    for (int c = 0; c < 8; c++) begin ex[c] = 16'(4 * c); ey[c] = 16'(65534 + 4 * c); end
    send("C", 16'd0, 16'hFFFE, 16'd32, 16'd32, 2'd3, 1'b1);
    beats("C", 8, 1'b1, 1'b0, -1, -1);

    // D: half-step slope exposes floor versus round-half-up.
    for (int c = 0; c < 32; c++) begin
`ifdef COORD_ROUND_EN
      ex[c] = 16'(100 + (c + 1) / 2);
`else
      ex[c] = 16'(100 + c / 2);
`endif
      ey[c] = 16'd0;
    end
    send("D", 16'd100, 16'd0, 16'd16, 16'd0, 2'd0, 1'b0);
    beats("D", 32, 1'b0, 1'b0, -1, -1);

    // S: out_ready dropped for 3 cycles at column 5.
    for (int c = 0; c < 32; c++) begin ex[c] = 16'(200 + c); ey[c] = 16'(10 - c); end
    send("S", 16'd200, 16'd10, 16'd32, 16'hFFE0, 2'd0, 1'b1);
    beats("S", 32, 1'b1, 1'b0, 5, -1);

    // E then F: F offered throughout E and taken on E's last beat.
    for (int c = 0; c < 8; c++) begin ex[c] = 16'(10 + 4 * c); ey[c] = 16'd20; end
    send("E", 16'd10, 16'd20, 16'd32, 16'd0, 2'd2, 1'b1);
    in_start_x = 16'd1000;
    in_start_y = 16'd2000;
    in_dx      = 16'd0;
    in_dy      = 16'd32;
    in_mode    = 2'd2;
    in_gray    = 1'b0;
    in_valid   = 1'b1;
    beats("E", 8, 1'b1, 1'b1, -1, -1);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin ex[c] = 16'd1000; ey[c] = 16'(2000 + 4 * c); end
    beats("F", 8, 1'b0, 1'b0, -1, -1);

    // R: reset pulse at column 10 abandons the run.
    for (int c = 0; c < 32; c++) begin ex[c] = 16'(300 + c); ey[c] = 16'd0; end
    send("R", 16'd300, 16'd0, 16'd32, 16'd0, 2'd0, 1'b1);
    beats("R", 32, 1'b1, 1'b0, -1, 10);

    // G: fresh command after the abort runs from column 0.
    for (int c = 0; c < 32; c++) begin ex[c] = 16'(7 + c); ey[c] = 16'(8 + c); end
    send("G", 16'd7, 16'd8, 16'd32, 16'd32, 2'd0, 1'b1);
    beats("G", 32, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
